// File: rtl/register_bank.sv
// 32-entry MIPS GPR file (WB writer, two ID read ports) with a handshaked dump sequencer.
// Define WRITE_BYPASS_EN for write-first read ports; the default build is read-first.
module register_bank #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic               i_wb_regwrite,
  input  logic [NB_ADDR-1:0] i_wb_rd,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  localparam int unsigned NREGS = 2 ** NB_ADDR;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] idx_q, idx_d;
  logic [NB_ADDR-1:0] idx_nxt;
  logic [NB_ADDR-1:0] dump_addr_q, dump_addr_d;
  logic [NB_DATA-1:0] dump_data_q, dump_data_d;
  logic [NB_DATA-1:0] regs_q [NREGS];
  logic               wr_en;

  assign wr_en = i_wb_regwrite && (i_wb_rd != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_wb_rd] <= i_wb_data;
    end
  end

  always_comb begin
    o_rs_data = (i_rs_addr == '0) ? '0 : regs_q[i_rs_addr];
    o_rt_data = (i_rt_addr == '0) ? '0 : regs_q[i_rt_addr];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (i_wb_rd == i_rs_addr)) o_rs_data = i_wb_data;
    if (wr_en && (i_wb_rd == i_rt_addr)) o_rt_data = i_wb_data;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign idx_nxt = idx_q + NB_ADDR'(1);

  // The next word is loaded from pre-edge contents, so each dumped value is a snapshot.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    o_dump_busy  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d     = SEND;
          idx_d       = '0;
          dump_addr_d = '0;
          dump_data_d = '0;
        end
      end
      SEND: begin
        o_dump_valid = 1'b1;
        if (i_dump_ready) begin
          if (idx_q == NB_ADDR'(NREGS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d       = idx_nxt;
            dump_addr_d = idx_nxt;
            dump_data_d = regs_q[idx_nxt];
          end
        end
      end
      DONE: begin
        o_dump_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dump_data = dump_data_q;
  assign o_dump_addr = dump_addr_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: random traffic against an array model of the GPR file.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wb_rd, dump_addr;
  logic [31:0] rs_data, rt_data, wb_data, dump_data;
  logic        wb_regwrite, dump_start, dump_ready;
  logic        dump_valid, dump_busy, dump_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [32];

  register_bank #(.NB_DATA(32), .NB_ADDR(5)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr),
    .o_rs_data(rs_data), .o_rt_data(rt_data),
    .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready),
    .o_dump_valid(dump_valid), .o_dump_data(dump_data), .o_dump_addr(dump_addr),
    .o_dump_busy(dump_busy), .o_dump_done(dump_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef WRITE_BYPASS_EN
    if (wb_regwrite && wb_rd != 0 && wb_rd == a) return wb_data;
`endif
    return model[a];
  endfunction

  task automatic tick();
    if (wb_regwrite && wb_rd != 0) model[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_regwrite = 1'b0;
    dump_start = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_data !== 0 || dump_addr !== 0) begin
      n_fail++;
      $display("FAIL reset_dump_outs: got v/b/d=%b%b%b data=%h addr=%0d, want 000/0/0",
               dump_valid, dump_busy, dump_done, dump_data, dump_addr);
    end
    for (int i = 0; i < 32; i += 4) begin
      rs_addr = 5'(i); rt_addr = 5'(i + 3); #1;
      n_tests++;
      if (rs_data !== 0 || rt_data !== 0) begin
        n_fail++;
        $display("FAIL reset_regs: $%0d=%h $%0d=%h, want 0", i, rs_data, i + 3, rt_data);
      end
    end
  endtask

  task automatic test_write_read();
    // T1 / T2
    wb_regwrite = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; tick();
    wb_rd = 0; wb_data = 32'hFFFFFFFF; tick();
    wb_regwrite = 0; rs_addr = 5; rt_addr = 0; #1;
    n_tests++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'h0) begin
      n_fail++;
      $display("FAIL t1_t2_read: rs=%h rt=%h, want deadbeef/00000000", rs_data, rt_data);
    end
    for (int it = 0; it < 60; it++) begin
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 31));
      wb_data = $urandom;
      rs_addr = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      #1;
      n_tests++;
      if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr)) begin
        n_fail++;
        $display("FAIL rand_read it=%0d: rs[%0d]=%h want %h, rt[%0d]=%h want %h", it,
                 rs_addr, rs_data, exp_read(rs_addr), rt_addr, rt_data, exp_read(rt_addr));
      end
      tick();
    end
    wb_regwrite = 0;
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    do_reset();
    wb_regwrite = 1; wb_rd = 7; wb_data = 32'h12345678; rs_addr = 7; rt_addr = 7; #1;
`ifdef WRITE_BYPASS_EN
    want = 32'h12345678;
`else
    want = 32'h0;
`endif
    n_tests++;
    if (rs_data !== want || rt_data !== want) begin
      n_fail++;
      $display("FAIL t3_bypass: rs=%h rt=%h, want %h", rs_data, rt_data, want);
    end
    tick();
    wb_regwrite = 0; #1;
    n_tests++;
    if (rs_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL t3_after: rs=%h, want 12345678", rs_data);
    end
  endtask

  task automatic preload_times4();
    for (int i = 0; i < 32; i++) begin
      wb_regwrite = 1; wb_rd = 5'(i); wb_data = 32'(i * 4); tick();
    end
    wb_regwrite = 0;
  endtask

  // bp: ready pattern 1,0,0 with stray start pulses and random writes; abort_at >= 0 resets mid-dump.
  task automatic run_dump(input bit bp, input int abort_at);
    logic [31:0] snap;
    int k = 0, xfers = 0, cyc = 1;
    bit done_seen = 0;
    dump_start = 1; snap = 32'h0; tick(); dump_start = 0;
    for (int guard = 0; guard < 300 && !done_seen; guard++) begin
      if (abort_at >= 0 && xfers == abort_at) begin
        rst = 1; wb_regwrite = 0; dump_start = 0; tick(); rst = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        n_tests++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
          n_fail++;
          $display("FAIL t6_abort_flags: v/b/d=%b%b%b, want 000", dump_valid, dump_busy, dump_done);
        end
        for (int i = 1; i < 32; i++) begin
          rs_addr = 5'(i); #1;
          n_tests++;
          if (rs_data !== 0) begin
            n_fail++;
            $display("FAIL t6_cleared: $%0d=%h, want 0", i, rs_data);
          end
        end
        return;
      end
      dump_ready = bp ? ((cyc - 1) % 3 == 0) : 1'b1;
      dump_start = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      wb_regwrite = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_rd = 5'($urandom_range(0, 31));
      if (k < 31 && wb_rd == 5'(k + 1)) wb_rd = 0;
      wb_data = $urandom;
      #1;
      if (dump_done) begin
        done_seen = 1;
        n_tests++;
        if (xfers != 32 || dump_valid !== 0 || (!bp && cyc != 33)) begin
          n_fail++;
          $display("FAIL dump_done: cyc=%0d xfers=%0d valid=%b, want xfers=32 valid=0%s",
                   cyc, xfers, dump_valid, bp ? "" : " cyc=33");
        end
      end else begin
        n_tests++;
        if (dump_valid !== 1 || dump_busy !== 1 || dump_addr !== 5'(k) || dump_data !== snap) begin
          n_fail++;
          $display("FAIL dump_word cyc=%0d: v=%b b=%b addr=%0d data=%h, want 1 1 %0d %h",
                   cyc, dump_valid, dump_busy, dump_addr, dump_data, k, snap);
        end
        if (dump_ready) begin
          xfers++;
          if (k < 31) begin
            snap = model[k + 1];
            k++;
          end
        end
      end
      tick();
      cyc++;
    end
    dump_start = 0; wb_regwrite = 0; dump_ready = 0;
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL dump_timeout: got xfers=%0d without done, want done after 32", xfers);
    end
    #1;
    n_tests++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL dump_idle_after: cyc=%0d v/b/d=%b%b%b, want 000",
               cyc, dump_valid, dump_busy, dump_done);
    end
    tick();
    n_tests++;
    if (dump_busy !== 0) begin
      n_fail++;
      $display("FAIL dump_no_rearm: busy=%b, want 0", dump_busy);
    end
  endtask

  task automatic test_full_dump();
    do_reset();
    preload_times4();
    run_dump(1'b0, -1);
  endtask

  task automatic test_backpressure();
    do_reset();
    preload_times4();
    for (int i = 1; i < 32; i++) begin
      wb_regwrite = 1; wb_rd = 5'(i); wb_data = $urandom; tick();
    end
    wb_regwrite = 0;
    run_dump(1'b1, -1);
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    preload_times4();
    run_dump(1'b0, 10);
    wb_regwrite = 1; wb_rd = 3; wb_data = 32'hA5A5_0003; tick();
    wb_regwrite = 0;
    run_dump(1'b0, -1);
  endtask

  initial begin
    rst = 1; rs_addr = 0; rt_addr = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    dump_start = 0; dump_ready = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
